core_block_ctrl: RTL and testbench

Per-core block controller, the core-side end of the block dispatch handshake. It accepts a block assignment (start pulse, block ID, thread count) and derives the per-thread enables and global thread IDs. It then sequences the block's instructions: fetch, decode, a lane execute handshake and PC update. When a return instruction is decoded it emits a single-cycle done pulse. One instance sits in each compute core, between the dispatcher and that core's thread lanes and instruction fetch port.

---
 rtl/core_block_ctrl_if.sv | 76 +++++++
 rtl/core_block_ctrl.sv | 136 +++++++++++++
 tb/tb_core_block_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/core_block_ctrl_if.sv
// Dispatcher/fetch/lane signal bundle for core_block_ctrl.
// block_cycles/instr_count exist only when BLOCK_PERF_CNT_EN is defined.
interface core_block_ctrl_if #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_W              = 8
);
  localparam int CNT_W = $clog2(THREADS_PER_BLOCK) + 1;

  logic                           core_reset;
  logic                           start;
  logic [7:0]                     block_id;
  logic [CNT_W-1:0]               thread_count;
  logic                           done;
  logic                           busy;
  logic [THREADS_PER_BLOCK-1:0]   thread_en;
  logic [8*THREADS_PER_BLOCK-1:0] thread_id;
  logic [PC_W-1:0]                pc;
  logic                           instr_req;
  logic [PC_W-1:0]                instr_addr;
  logic                           instr_valid;
  logic [15:0]                    instr_data;
  logic [15:0]                    instr_out;
  logic                           lane_start;
  logic [THREADS_PER_BLOCK-1:0]   lane_busy;
`ifdef BLOCK_PERF_CNT_EN
  logic [15:0]                    block_cycles;
  logic [15:0]                    instr_count;
`endif

  // slave: the per-core controller; master: dispatcher, fetch port and lanes
  modport slave (
`ifdef BLOCK_PERF_CNT_EN
    output block_cycles,
    output instr_count,
`endif
    input  core_reset,
    input  start,
    input  block_id,
    input  thread_count,
    output done,
    output busy,
    output thread_en,
    output thread_id,
    output pc,
    output instr_req,
    output instr_addr,
    input  instr_valid,
    input  instr_data,
    output instr_out,
    output lane_start,
    input  lane_busy
  );

  modport master (
`ifdef BLOCK_PERF_CNT_EN
    input  block_cycles,
    input  instr_count,
`endif
    output core_reset,
    output start,
    output block_id,
    output thread_count,
    input  done,
    input  busy,
    input  thread_en,
    input  thread_id,
    input  pc,
    input  instr_req,
    input  instr_addr,
    output instr_valid,
    output instr_data,
    input  instr_out,
    input  lane_start,
    output lane_busy
  );
endinterface

// File: rtl/core_block_ctrl.sv
// Per-core block controller: accepts a block assignment, then runs fetch/decode/execute
// until a return opcode. Optional perf counters are enabled by defining BLOCK_PERF_CNT_EN.
module core_block_ctrl #(
  parameter int         THREADS_PER_BLOCK = 4,
  parameter int         PC_W              = 8,
  parameter logic [3:0] RET_OPCODE        = 4'hF
) (
  input logic              clk,
  input logic              reset,
  core_block_ctrl_if.slave bus
);
  localparam int CNT_W  = $clog2(THREADS_PER_BLOCK) + 1;
  localparam int LOG2_T = $clog2(THREADS_PER_BLOCK);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT, S_UPDATE, S_DONE
  } state_t;

  state_t                         state_q, state_d;
  logic [THREADS_PER_BLOCK-1:0]   thread_en_q;
  logic [8*THREADS_PER_BLOCK-1:0] thread_id_q;
  logic [PC_W-1:0]                pc_q;
  logic [15:0]                    instr_out_q;

  logic                           accept;
  logic [CNT_W-1:0]               cnt_clamped;
  logic [7:0]                     id_base;
  logic [THREADS_PER_BLOCK-1:0]   en_new;
  logic [8*THREADS_PER_BLOCK-1:0] id_new;

  assign accept      = (state_q == S_IDLE) && bus.start;
  assign cnt_clamped = (bus.thread_count > CNT_W'(THREADS_PER_BLOCK)) ?
                       CNT_W'(THREADS_PER_BLOCK) : bus.thread_count;
  assign id_base     = bus.block_id << LOG2_T;

  // Every lane gets its global ID, enabled or not, so debug sees the whole block.
  genvar gi;
  generate
    for (gi = 0; gi < THREADS_PER_BLOCK; gi++) begin : g_lane
      assign en_new[gi]          = (CNT_W'(gi) < cnt_clamped);
      assign id_new[8*gi +: 8]   = id_base + 8'(gi);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else if (bus.core_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = (cnt_clamped == '0) ? S_DONE : S_FETCH;
      S_FETCH:  if (bus.instr_valid) state_d = S_DECODE;
      S_DECODE: state_d = (instr_out_q[15:12] == RET_OPCODE) ? S_DONE : S_EXEC;
      S_EXEC:   state_d = S_WAIT;
      S_WAIT:   if ((bus.lane_busy & thread_en_q) == '0) state_d = S_UPDATE;
      S_UPDATE: state_d = S_FETCH;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // pc, thread_id and instr_out are deliberately left alone after DONE for debug.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      thread_en_q <= '0;
      thread_id_q <= '0;
      pc_q        <= '0;
      instr_out_q <= '0;
    end else if (bus.core_reset) begin
      thread_en_q <= '0;
      thread_id_q <= '0;
      pc_q        <= '0;
      instr_out_q <= '0;
    end else begin
      if (accept) begin
        thread_en_q <= en_new;
        thread_id_q <= id_new;
        pc_q        <= '0;
      end
      if (state_q == S_FETCH && bus.instr_valid) begin
        instr_out_q <= bus.instr_data;
      end
      if (state_q == S_UPDATE) begin
        pc_q <= pc_q + PC_W'(1);
      end
      if (state_q == S_DONE) begin
        thread_en_q <= '0;
      end
    end
  end

  assign bus.done       = (state_q == S_DONE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.thread_en  = thread_en_q;
  assign bus.thread_id  = thread_id_q;
  assign bus.pc         = pc_q;
  assign bus.instr_req  = (state_q == S_FETCH);
  assign bus.instr_addr = pc_q;
  assign bus.instr_out  = instr_out_q;
  assign bus.lane_start = (state_q == S_EXEC);

`ifdef BLOCK_PERF_CNT_EN
  logic [15:0] block_cycles_q;
  logic [15:0] instr_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      block_cycles_q <= '0;
      instr_count_q  <= '0;
    end else if (bus.core_reset) begin
      block_cycles_q <= '0;
      instr_count_q  <= '0;
    end else if (accept) begin
      block_cycles_q <= '0;
      instr_count_q  <= '0;
    end else begin
      if (state_q != S_IDLE && block_cycles_q != 16'hFFFF) begin
        block_cycles_q <= block_cycles_q + 16'd1;
      end
      if (state_q == S_UPDATE && instr_count_q != 16'hFFFF) begin
        instr_count_q <= instr_count_q + 16'd1;
      end
    end
  end

  assign bus.block_cycles = block_cycles_q;
  assign bus.instr_count  = instr_count_q;
`endif
endmodule

// File: tb/tb_core_block_ctrl.sv
// Scoreboard bench for core_block_ctrl: instruction memory and lane models respond
// to the DUT; expected per-block results are queued at start and checked at done.
module tb_core_block_ctrl;
  localparam int T    = 4;
  localparam int PC_W = 8;

  typedef struct {
    logic [3:0]  en;
    logic [31:0] ids;
    logic [7:0]  pc;
    logic [15:0] instr;
    int          lat;
    int          n;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  core_block_ctrl_if #(.THREADS_PER_BLOCK(T), .PC_W(PC_W)) bus ();

  core_block_ctrl #(.THREADS_PER_BLOCK(T), .PC_W(PC_W), .RET_OPCODE(4'hF)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          total = 0;
  int          bad   = 0;
  exp_t        sb[$];
  logic [15:0] mem [0:31];
  int          cfg_stall = 0;
  int          cfg_hold  = 0;
  logic [3:0]  cfg_force = 4'h0;
  logic [15:0] prev_ret  = 16'h0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Instruction memory: stalls cfg_stall cycles per fetch, then returns mem[fetch index].
  int          fetch_idx = 0;
  int          stall_ctr = 0;
  int          req_total = 0;
  logic [15:0] last_data = 16'h0;
  always begin
    @(posedge clk);
    #1;
    if (!reset || bus.core_reset) begin
      bus.instr_valid = 1'b0;
      fetch_idx = 0;
      stall_ctr = 0;
      last_data = 16'h0;
    end else begin
      if (bus.instr_valid) begin
        check_eq("instr_out_latch", bus.instr_out, bus.instr_data);
        last_data = bus.instr_data;
        fetch_idx++;
        bus.instr_valid = 1'b0;
      end
      if (!bus.busy) fetch_idx = 0;
      if (bus.instr_req) begin
        req_total++;
        check_eq("fetch_addr", bus.instr_addr, fetch_idx);
        if (stall_ctr < cfg_stall) begin
          check_eq("stall_instr_out", bus.instr_out, last_data);
          stall_ctr++;
        end else begin
          bus.instr_valid = 1'b1;
          bus.instr_data  = mem[fetch_idx];
          stall_ctr = 0;
        end
      end
    end
  end

  // Lanes: all four stay busy for cfg_hold WAIT cycles; cfg_force lanes stay busy always.
  int rem = 0;
  always begin
    @(posedge clk);
    #1;
    if (!reset || bus.core_reset) begin
      rem = 0;
      bus.lane_busy = 4'h0;
    end else if (bus.lane_start) begin
      rem = cfg_hold;
      bus.lane_busy = cfg_force;
    end else begin
      bus.lane_busy = ((rem > 0) ? 4'hF : 4'h0) | cfg_force;
      if (rem > 0) rem--;
    end
  end

  task automatic run_block(input int bid, input int tc, input int n, input int op0,
                           input int stall, input int hold, input logic [3:0] force_mask,
                           input int collide_cyc);
    exp_t e;
    exp_t got;
    int   cnt;
    int   cyc;
    int   req0;
    cfg_stall = stall;
    cfg_hold  = hold;
    cfg_force = force_mask;
    for (int k = 0; k < n; k++) mem[k] = {4'((op0 + k) % 15), 12'(bid * 16 + k)};
    mem[n] = {4'hF, 12'(bid)};
    cnt   = (tc > T) ? T : tc;
    e.en  = 4'((1 << cnt) - 1);
    for (int i = 0; i < T; i++) e.ids[8*i +: 8] = 8'((bid * T + i) % 256);
    e.pc    = (cnt == 0) ? 8'd0 : 8'(n);
    e.instr = (cnt == 0) ? prev_ret : mem[n];
    e.lat   = (cnt == 0) ? 1 : n * (5 + stall + hold) + stall + 3;
    e.n     = (cnt == 0) ? 0 : n;
    sb.push_back(e);
    req0 = req_total;

    @(negedge clk);
    bus.start        = 1'b1;
    bus.block_id     = 8'(bid);
    bus.thread_count = 3'(tc);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    check_eq("en_at_start", bus.thread_en, e.en);
    while (!bus.done && cyc < 400) begin
      if (cyc == collide_cyc) begin
        bus.start        = 1'b1;
        bus.block_id     = 8'(bid) ^ 8'h5A;
        bus.thread_count = 3'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    got = sb.pop_front();
    check_eq("done_latency", cyc, got.lat);
    check_eq("thread_en", bus.thread_en, got.en);
    check_eq("thread_id", bus.thread_id, got.ids);
    check_eq("pc_at_done", bus.pc, got.pc);
    check_eq("instr_out", bus.instr_out, got.instr);
    check_eq("busy_at_done", bus.busy, 1'b1);
    if (cnt == 0) check_eq("no_instr_req", req_total - req0, 0);
    @(negedge clk);
    check_eq("done_one_cycle", bus.done, 1'b0);
    check_eq("busy_after", bus.busy, 1'b0);
    check_eq("en_after", bus.thread_en, 4'h0);
    check_eq("pc_hold", bus.pc, got.pc);
    check_eq("id_hold", bus.thread_id, got.ids);
`ifdef BLOCK_PERF_CNT_EN
    check_eq("block_cycles", bus.block_cycles, got.lat);
    check_eq("instr_count", bus.instr_count, got.n);
`endif
    if (cnt != 0) prev_ret = mem[n];
    $display("block bid=%0d tc=%0d n=%0d stall=%0d hold=%0d latency=%0d", bid, tc, n, stall, hold, cyc);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_outs"},
             {bus.done, bus.busy, bus.thread_en, bus.pc, bus.instr_req, bus.instr_addr,
              bus.instr_out, bus.lane_start}, 0);
    check_eq({tag, "_ids"}, bus.thread_id, 0);
  endtask

  initial begin
    int cyc;
    int done_cnt;
    reset            = 1'b0;
    bus.core_reset   = 1'b0;
    bus.start        = 1'b0;
    bus.block_id     = 8'h0;
    bus.thread_count = 3'd0;
    bus.instr_valid  = 1'b0;
    bus.instr_data   = 16'h0;
    bus.lane_busy    = 4'h0;
    for (int k = 0; k < 32; k++) mem[k] = 16'h0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    run_block(2,   4, 2, 1,  0, 0, 4'h0, 0);  // full block, 13-cycle latency
    run_block(3,   2, 2, 3,  0, 2, 4'hC, 0);  // partial, disabled lanes stuck busy
    run_block(5,   0, 2, 1,  0, 0, 4'h0, 0);  // zero threads
    run_block(7,   3, 1, 14, 5, 0, 4'h0, 0);  // fetch stall, opcode E is not a return
    run_block(1,   4, 1, 2,  5, 1, 4'h0, 2);  // second start during FETCH
    run_block(255, 5, 2, 6,  0, 0, 4'h0, 0);  // count clamp and ID wrap

    // Soft reset in WAIT aborts without done.
    cfg_stall = 0;
    cfg_hold  = 30;
    cfg_force = 4'h0;
    for (int k = 0; k < 3; k++) mem[k] = 16'h1111;
    @(negedge clk);
    bus.start        = 1'b1;
    bus.block_id     = 8'd6;
    bus.thread_count = 3'd4;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.lane_start && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("reach_exec", bus.lane_start, 1'b1);
    @(negedge clk);
    check_eq("in_wait", bus.busy, 1'b1);
    bus.core_reset = 1'b1;
    @(negedge clk);
    bus.core_reset = 1'b0;
    check_all_zero("soft_reset");
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check_eq("no_done_after_abort", done_cnt, 0);
    prev_ret = 16'h0;

    run_block(64, 1, 3, 4, 1, 1, 4'h0, 0);     // normal block after soft reset

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
